// File: rtl/overture_regfile_stage_if.sv
// rtl/overture_regfile_stage_if.sv - instruction, ALU, I/O and jump signals of the register-file stage
interface overture_regfile_stage_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] alu_code;
  logic [7:0] alu_in1;
  logic [7:0] alu_in2;
  logic [7:0] alu_result;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_out_valid;
  logic       jump_taken;
  logic [7:0] jump_addr;

  modport master (
    output instr, instr_valid, alu_result, io_in,
    input  instr_ready, alu_code, alu_in1, alu_in2, io_out, io_out_valid,
           jump_taken, jump_addr
  );

  modport slave (
    input  instr, instr_valid, alu_result, io_in,
    output instr_ready, alu_code, alu_in1, alu_in2, io_out, io_out_valid,
           jump_taken, jump_addr
  );
endinterface

// File: rtl/overture_regfile_stage.sv
// rtl/overture_regfile_stage.sv - six-register issue stage with ALU launch, copy and conditional jump
// OVERTURE_FWD_EN: forward alu_result to reg3 readers instead of stalling one cycle.
module overture_regfile_stage #(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input logic                     clk,
  input logic                     rst,
  overture_regfile_stage_if.slave bus
);

  localparam logic [1:0] CLS_IMM  = 2'b00;
  localparam logic [1:0] CLS_ALU  = 2'b01;
  localparam logic [1:0] CLS_COPY = 2'b10;
  localparam logic [1:0] CLS_COND = 2'b11;

  logic unused_params;
  assign unused_params = ^{UUID, NAME};

  logic [7:0] reg_q [6];
  logic [7:0] reg_d [6];
  logic       ex_valid_q, ex_valid_d;
  logic [7:0] alu_code_q, alu_code_d;
  logic [7:0] alu_in1_q, alu_in1_d;
  logic [7:0] alu_in2_q, alu_in2_d;
  logic [7:0] io_out_q, io_out_d;
  logic       io_out_valid_q, io_out_valid_d;
  logic       jump_taken_q, jump_taken_d;
  logic [7:0] jump_addr_q, jump_addr_d;

  logic [1:0] cls;
  logic [2:0] src;
  logic [2:0] dst;
  logic       is_hazard;
  logic       ready;
  logic       accept;
  logic [7:0] reg3_rd;
  logic [7:0] src_val;
  logic       cond_true;

  assign cls       = bus.instr[7:6];
  assign src       = bus.instr[5:3];
  assign dst       = bus.instr[2:0];
  assign is_hazard = (cls == CLS_COND) || ((cls == CLS_COPY) && (src == 3'd3));

`ifdef OVERTURE_FWD_EN
  assign ready   = 1'b1;
  assign reg3_rd = ex_valid_q ? bus.alu_result : reg_q[3];
  logic unused_hazard;
  assign unused_hazard = is_hazard;
`else
  // Hold a reg3 reader back until the in-flight ALU result has landed in reg3.
  assign ready   = !(bus.instr_valid && ex_valid_q && is_hazard);
  assign reg3_rd = reg_q[3];
`endif

  assign accept = bus.instr_valid && ready;

  always_comb begin
    src_val = 8'h00;
    case (src)
      3'd3:    src_val = reg3_rd;
      3'd6:    src_val = bus.io_in;
      3'd7:    src_val = 8'h00;
      default: src_val = reg_q[src];
    endcase
  end

  // Condition codes test reg3 as a two's-complement value via its sign bit.
  always_comb begin
    cond_true = 1'b0;
    case (dst)
      3'd0: cond_true = 1'b0;
      3'd1: cond_true = (reg3_rd == 8'h00);
      3'd2: cond_true = reg3_rd[7];
      3'd3: cond_true = reg3_rd[7] || (reg3_rd == 8'h00);
      3'd4: cond_true = 1'b1;
      3'd5: cond_true = (reg3_rd != 8'h00);
      3'd6: cond_true = !reg3_rd[7];
      3'd7: cond_true = !reg3_rd[7] && (reg3_rd != 8'h00);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    reg_d          = reg_q;
    ex_valid_d     = 1'b0;
    alu_code_d     = alu_code_q;
    alu_in1_d      = alu_in1_q;
    alu_in2_d      = alu_in2_q;
    io_out_d       = io_out_q;
    io_out_valid_d = 1'b0;
    jump_taken_d   = 1'b0;
    jump_addr_d    = jump_addr_q;

    if (ex_valid_q) begin
      reg_d[3] = bus.alu_result;
    end

    // Issuing instruction is applied after writeback so a copy into reg3 wins.
    if (accept) begin
      case (cls)
        CLS_IMM: reg_d[0] = {2'b00, bus.instr[5:0]};
        CLS_ALU: begin
          ex_valid_d = 1'b1;
          alu_code_d = {5'b00000, bus.instr[2:0]};
          alu_in1_d  = reg_q[1];
          alu_in2_d  = reg_q[2];
        end
        CLS_COPY: begin
          for (int i = 0; i < 6; i++) begin
            if (dst == 3'(i)) begin
              reg_d[i] = src_val;
            end
          end
          if (dst == 3'd6) begin
            io_out_d       = src_val;
            io_out_valid_d = 1'b1;
          end
        end
        CLS_COND: begin
          if (cond_true) begin
            jump_taken_d = 1'b1;
            jump_addr_d  = reg_q[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) begin
        reg_q[i] <= 8'h00;
      end
      ex_valid_q     <= 1'b0;
      alu_code_q     <= 8'h00;
      alu_in1_q      <= 8'h00;
      alu_in2_q      <= 8'h00;
      io_out_q       <= 8'h00;
      io_out_valid_q <= 1'b0;
      jump_taken_q   <= 1'b0;
      jump_addr_q    <= 8'h00;
    end else begin
      reg_q          <= reg_d;
      ex_valid_q     <= ex_valid_d;
      alu_code_q     <= alu_code_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      io_out_q       <= io_out_d;
      io_out_valid_q <= io_out_valid_d;
      jump_taken_q   <= jump_taken_d;
      jump_addr_q    <= jump_addr_d;
    end
  end

  assign bus.instr_ready  = ready;
  assign bus.alu_code     = alu_code_q;
  assign bus.alu_in1      = alu_in1_q;
  assign bus.alu_in2      = alu_in2_q;
  assign bus.io_out       = io_out_q;
  assign bus.io_out_valid = io_out_valid_q;
  assign bus.jump_taken   = jump_taken_q;
  assign bus.jump_addr    = jump_addr_q;

endmodule

// File: tb/tb_overture_regfile_stage.sv
// tb/tb_overture_regfile_stage.sv - directed and random checks of overture_regfile_stage against a reference model
module tb_overture_regfile_stage;

`ifdef OVERTURE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  overture_regfile_stage_if bus ();

  overture_regfile_stage #(.UUID(0), .NAME("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Architectural state as the programmer sees it.
  logic [7:0] m_reg [6];
  logic       m_ex;
  logic [7:0] m_code, m_a, m_b, m_io, m_ja;
  logic       m_iov, m_jt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_reg3(input logic [7:0] ins);
    return (ins[7:6] == 2'b11) || (ins[7:6] == 2'b10 && ins[5:3] == 3'd3);
  endfunction

  function automatic bit cond_holds(input logic [2:0] cc, input int v);
    case (cc)
      3'd0: return 1'b0;
      3'd1: return v == 0;
      3'd2: return v < 0;
      3'd3: return v <= 0;
      3'd4: return 1'b1;
      3'd5: return v != 0;
      3'd6: return v >= 0;
      default: return v > 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = 8'h00;
    m_ex = 0; m_code = 0; m_a = 0; m_b = 0; m_io = 0; m_ja = 0; m_iov = 0; m_jt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".alu_code"}, bus.alu_code, m_code);
    chk({tag, ".alu_in1"}, bus.alu_in1, m_a);
    chk({tag, ".alu_in2"}, bus.alu_in2, m_b);
    chk({tag, ".io_out"}, bus.io_out, m_io);
    chk({tag, ".io_out_valid"}, {7'b0, bus.io_out_valid}, {7'b0, m_iov});
    chk({tag, ".jump_taken"}, {7'b0, bus.jump_taken}, {7'b0, m_jt});
    chk({tag, ".jump_addr"}, bus.jump_addr, m_ja);
  endtask

  // Starts at a falling edge, presents inputs for one clock, ends at the next falling edge.
  task automatic cycle(input logic [7:0] ins, input logic v, input logic [7:0] ar,
                       input logic [7:0] ii, output bit acc);
    logic [7:0] n_reg [6];
    logic [7:0] rv3, sv;
    bit exp_rdy;
    bus.instr = ins; bus.instr_valid = v; bus.alu_result = ar; bus.io_in = ii;
    #1;
    exp_rdy = FWD ? 1'b1 : !(v && m_ex && reads_reg3(ins));
    chk("instr_ready", {7'b0, bus.instr_ready}, {7'b0, exp_rdy});
    acc = v && exp_rdy;
    rv3 = (FWD && m_ex) ? ar : m_reg[3];
    if (ins[5:3] == 3'd3) sv = rv3;
    else if (ins[5:3] < 3'd6) sv = m_reg[ins[5:3]];
    else if (ins[5:3] == 3'd6) sv = ii;
    else sv = 8'h00;
    n_reg = m_reg;
    if (m_ex) n_reg[3] = ar;
    m_ex = acc && ins[7:6] == 2'b01;
    m_iov = 0;
    m_jt = 0;
    if (acc) begin
      case (ins[7:6])
        2'b00: n_reg[0] = {2'b00, ins[5:0]};
        2'b01: begin m_code = {5'b0, ins[2:0]}; m_a = m_reg[1]; m_b = m_reg[2]; end
        2'b10: begin
          if (ins[2:0] < 3'd6) n_reg[ins[2:0]] = sv;
          else if (ins[2:0] == 3'd6) begin m_io = sv; m_iov = 1; end
        end
        default: if (cond_holds(ins[2:0], int'($signed(rv3)))) begin m_jt = 1; m_ja = m_reg[0]; end
      endcase
    end
    m_reg = n_reg;
    @(posedge clk);
    #1;
    check_outputs("cyc");
    @(negedge clk);
  endtask

  task automatic op(input logic [7:0] ins, input logic [7:0] ar = 8'h00, input logic [7:0] ii = 8'h00);
    bit a;
    cycle(ins, 1'b1, ar, ii, a);
  endtask

  task automatic idle(input logic [7:0] ar = 8'h00);
    bit a;
    cycle(8'h00, 1'b0, ar, 8'h00, a);
  endtask

  task automatic pulse_reset(input logic [7:0] ar);
    bus.instr_valid = 1'b0; bus.alu_result = ar;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    chk("reset.instr_ready", {7'b0, bus.instr_ready}, 8'h01);
    @(posedge clk); #1;
    chk("reset_hold.instr_ready", {7'b0, bus.instr_ready}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int stalls;
    logic [7:0] ins;
    bus.instr = 8'h00; bus.instr_valid = 1'b0; bus.alu_result = 8'h00; bus.io_in = 8'h00;
    model_reset();
    #2;
    check_outputs("por");
    chk("por.instr_ready", {7'b0, bus.instr_ready}, 8'h01);
    @(negedge clk);
    rst = 1'b1;

    // immediate then copy reg0 to io_out
    op(8'h3F);
    op(8'h86);
    chk("imm_copy.io_out", bus.io_out, 8'h3F);
    chk("imm_copy.pulse", {7'b0, bus.io_out_valid}, 8'h01);
    idle();
    chk("imm_copy.pulse_end", {7'b0, bus.io_out_valid}, 8'h00);

    // SUB of reg1=5, reg2=3 with ALU returning 2
    op(8'h05); op(8'h81); op(8'h03); op(8'h82);
    op(8'h45);
    chk("sub.alu_code", bus.alu_code, 8'h05);
    chk("sub.alu_in1", bus.alu_in1, 8'h05);
    chk("sub.alu_in2", bus.alu_in2, 8'h03);
    idle(8'h02);
    op(8'h9E);
    chk("sub.reg3", bus.io_out, 8'h02);

    // ADD then ==0 back-to-back
    op(8'h15);
    op(8'h40);
    stalls = 0;
    cycle(8'hC1, 1'b1, 8'h00, 8'h00, acc);
    for (int k = 0; k < 3 && !acc; k++) begin
      stalls++;
      cycle(8'hC1, 1'b1, 8'h00, 8'h00, acc);
    end
    chk("jump.accepted", {7'b0, acc}, 8'h01);
    chk("jump.stalls", 8'(stalls), FWD ? 8'h00 : 8'h01);
    chk("jump.taken", {7'b0, bus.jump_taken}, 8'h01);
    chk("jump.addr", bus.jump_addr, 8'h15);
    idle();
    chk("jump.pulse_end", {7'b0, bus.jump_taken}, 8'h00);

    // copy into reg3 beats the same-edge ALU writeback
    op(8'h2A); op(8'h84);
    op(8'h41);
    op(8'hA3, 8'h77);
    op(8'h9E);
    chk("order.reg3", bus.io_out, 8'h2A);

    // reset during the writeback cycle drops the result
    op(8'h42);
    pulse_reset(8'h55);
    op(8'h9E);
    chk("rst_wb.reg3", bus.io_out, 8'h00);

    // reg3 = -128: >0 false, <0 true
    op(8'hB3, 8'h00, 8'h80);
    op(8'hC7);
    chk("neg.gt", {7'b0, bus.jump_taken}, 8'h00);
    op(8'hC2);
    chk("neg.lt", {7'b0, bus.jump_taken}, 8'h01);

    // random traffic, a stalled instruction is held until accepted
    acc = 1'b1;
    ins = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if (acc || !bus.instr_valid) begin
        ins = 8'($urandom);
        if ($urandom_range(0, 3) == 0) ins[7:6] = 2'b01;
        bus.instr_valid = ($urandom_range(0, 3) != 0);
      end
      cycle(ins, bus.instr_valid, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
            8'($urandom), acc);
      if (n == 300) pulse_reset(8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
